// File: rtl/ysyx_23060240_trap_ctrl_pkg.sv
// Shared constants for the machine-mode trap sequencer: CSR addresses,
// mstatus field positions, cause codes and the sequencer state encoding.
package ysyx_23060240_trap_ctrl_pkg;

  localparam logic [11:0] CSR_MSTATUS = 12'h300;
  localparam logic [11:0] CSR_MTVEC   = 12'h305;
  localparam logic [11:0] CSR_MEPC    = 12'h341;
  localparam logic [11:0] CSR_MCAUSE  = 12'h342;

  localparam int MSTATUS_MIE    = 3;
  localparam int MSTATUS_MPIE   = 7;
  localparam int MSTATUS_MPP_LO = 11;
  localparam int MSTATUS_MPP_HI = 12;

  localparam logic [3:0] CAUSE_INST_MISALIGN = 4'd0;
  localparam logic [3:0] CAUSE_ILLEGAL       = 4'd2;
  localparam logic [3:0] CAUSE_MTIMER        = 4'd7;
  localparam logic [3:0] CAUSE_ECALL_M       = 4'd11;

  // T_* states belong to trap entry, M_* to mret; both paths end in S_REDIR.
  typedef enum logic [3:0] {
    S_IDLE,
    S_T_RSTAT,
    S_T_WEPC,
    S_T_WCAUSE,
    S_T_WSTAT,
    S_T_RTVEC,
    S_M_RSTAT,
    S_M_WSTAT,
    S_M_REPC,
    S_REDIR
  } state_e;

endpackage

// File: rtl/ysyx_23060240_trap_target.sv
// Turns the mtvec or mepc value read from the CSR file into the redirect PC,
// adding the vectored-interrupt offset for the machine-timer cause.
module ysyx_23060240_trap_target
  import ysyx_23060240_trap_ctrl_pkg::*;
#(
  parameter int XLEN      = 32,
  parameter bit VECTOR_EN = 1'b1
) (
  input  logic [XLEN-1:0] csr_val,
  input  logic            is_mret,
  input  logic            is_irq,
  output logic [XLEN-1:0] target
);

  localparam logic [XLEN-1:0] VEC_OFFSET = XLEN'(4 * int'(CAUSE_MTIMER));

  always_comb begin
    target = {csr_val[XLEN-1:2], 2'b00};
    if (VECTOR_EN && !is_mret && is_irq && (csr_val[1:0] == 2'b01))
      target = target + VEC_OFFSET;
  end

endmodule

// File: rtl/ysyx_23060240_trap_ctrl.sv
// Trap/mret sequencer: owns the CSR port for a fixed multi-cycle sequence,
// stalls the pipe while doing so, then hands the target PC to the fetch unit.
module ysyx_23060240_trap_ctrl
  import ysyx_23060240_trap_ctrl_pkg::*;
#(
  parameter int XLEN      = 32,
  parameter bit VECTOR_EN = 1'b1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            exc_valid_i,
  input  logic [3:0]      exc_cause_i,
  input  logic [XLEN-1:0] exc_pc_i,
  input  logic            mret_valid_i,
  input  logic            irq_i,
  output logic            req_ready_o,
  output logic            busy_o,
  output logic [11:0]     csr_addr_o,
  output logic            csr_re_o,
  input  logic [XLEN-1:0] csr_rdata_i,
  output logic            csr_we_o,
  output logic [XLEN-1:0] csr_wdata_o,
  input  logic            core_csr_we_i,
  input  logic [11:0]     core_csr_addr_i,
  input  logic [XLEN-1:0] core_csr_wdata_i,
  output logic            redir_valid_o,
  output logic [XLEN-1:0] redir_pc_o,
  input  logic            redir_ready_i
);

  state_e          state, state_nxt;
  logic [XLEN-1:0] pc_q, status_q, target_q, target_nxt;
  logic [3:0]      cause_q;
  logic            irq_q, mie_q;
  logic            take_trap, take_irq, take_mret;
  logic            unused_snoop_bits;

  assign unused_snoop_bits = ^{core_csr_wdata_i[XLEN-1:MSTATUS_MIE+1],
                               core_csr_wdata_i[MSTATUS_MIE-1:0]};

  function automatic logic [XLEN-1:0] status_on_trap(input logic [XLEN-1:0] s);
    logic [XLEN-1:0] r;
    r = s;
    r[MSTATUS_MPIE] = s[MSTATUS_MIE];
    r[MSTATUS_MIE]  = 1'b0;
    r[MSTATUS_MPP_HI:MSTATUS_MPP_LO] = 2'b11;
    return r;
  endfunction

  function automatic logic [XLEN-1:0] status_on_mret(input logic [XLEN-1:0] s);
    logic [XLEN-1:0] r;
    r = s;
    r[MSTATUS_MIE]  = s[MSTATUS_MPIE];
    r[MSTATUS_MPIE] = 1'b1;
    r[MSTATUS_MPP_HI:MSTATUS_MPP_LO] = 2'b11;
    return r;
  endfunction

  function automatic logic [XLEN-1:0] trap_cause(input logic irq, input logic [3:0] code);
    return irq ? {1'b1, {(XLEN-5){1'b0}}, CAUSE_MTIMER} : {{(XLEN-4){1'b0}}, code};
  endfunction

  // Priority: exception, then enabled interrupt, then mret.
  always_comb begin
    take_irq  = !exc_valid_i && irq_i && mie_q;
    take_trap = exc_valid_i || take_irq;
    take_mret = !take_trap && mret_valid_i;
  end

  ysyx_23060240_trap_target #(.XLEN(XLEN), .VECTOR_EN(VECTOR_EN)) u_target (
    .csr_val (csr_rdata_i),
    .is_mret (state == S_M_REPC),
    .is_irq  (irq_q),
    .target  (target_nxt)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:     if (take_trap) state_nxt = S_T_RSTAT;
                  else if (take_mret) state_nxt = S_M_RSTAT;
      S_T_RSTAT:  state_nxt = S_T_WEPC;
      S_T_WEPC:   state_nxt = S_T_WCAUSE;
      S_T_WCAUSE: state_nxt = S_T_WSTAT;
      S_T_WSTAT:  state_nxt = S_T_RTVEC;
      S_T_RTVEC:  state_nxt = S_REDIR;
      S_M_RSTAT:  state_nxt = S_M_WSTAT;
      S_M_WSTAT:  state_nxt = S_M_REPC;
      S_M_REPC:   state_nxt = S_REDIR;
      S_REDIR:    if (redir_ready_i) state_nxt = S_IDLE;
      default:    state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    req_ready_o   = (state == S_IDLE);
    busy_o        = (state != S_IDLE);
    csr_addr_o    = 12'h000;
    csr_re_o      = 1'b0;
    csr_we_o      = 1'b0;
    csr_wdata_o   = '0;
    redir_valid_o = 1'b0;
    redir_pc_o    = '0;
    case (state)
      S_T_RSTAT, S_M_RSTAT: begin
        csr_re_o = 1'b1; csr_addr_o = CSR_MSTATUS;
      end
      S_T_WEPC: begin
        csr_we_o = 1'b1; csr_addr_o = CSR_MEPC; csr_wdata_o = pc_q;
      end
      S_T_WCAUSE: begin
        csr_we_o = 1'b1; csr_addr_o = CSR_MCAUSE; csr_wdata_o = trap_cause(irq_q, cause_q);
      end
      S_T_WSTAT: begin
        csr_we_o = 1'b1; csr_addr_o = CSR_MSTATUS; csr_wdata_o = status_on_trap(status_q);
      end
      S_T_RTVEC: begin
        csr_re_o = 1'b1; csr_addr_o = CSR_MTVEC;
      end
      S_M_WSTAT: begin
        csr_we_o = 1'b1; csr_addr_o = CSR_MSTATUS; csr_wdata_o = status_on_mret(status_q);
      end
      S_M_REPC: begin
        csr_re_o = 1'b1; csr_addr_o = CSR_MEPC;
      end
      S_REDIR: begin
        redir_valid_o = 1'b1; redir_pc_o = target_q;
      end
      default: ;
    endcase
  end

  // mie_q mirrors mstatus.MIE; core snoop writes only land while idle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q     <= '0;
      status_q <= '0;
      target_q <= '0;
      cause_q  <= '0;
      irq_q    <= 1'b0;
      mie_q    <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (take_trap) begin
            pc_q    <= exc_pc_i;
            cause_q <= exc_cause_i;
            irq_q   <= take_irq;
          end else if (take_mret) begin
            irq_q   <= 1'b0;
          end
          if (core_csr_we_i && (core_csr_addr_i == CSR_MSTATUS))
            mie_q <= core_csr_wdata_i[MSTATUS_MIE];
        end
        S_T_RSTAT, S_M_RSTAT: status_q <= csr_rdata_i;
        S_T_WSTAT:            mie_q    <= 1'b0;
        S_M_WSTAT:            mie_q    <= status_q[MSTATUS_MPIE];
        S_T_RTVEC, S_M_REPC:  target_q <= target_nxt;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_ysyx_23060240_trap_ctrl.sv
// Bench for the trap sequencer: a small CSR file answers the DUT's port and an
// abstract model predicts CSR contents, redirect PC and latency per request.
module tb_ysyx_23060240_trap_ctrl;

  localparam int XLEN = 32;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            exc_valid = 1'b0;
  logic [3:0]      exc_cause = '0;
  logic [XLEN-1:0] exc_pc = '0;
  logic            mret_valid = 1'b0;
  logic            irq = 1'b0;
  logic            req_ready, busy;
  logic [11:0]     csr_addr;
  logic            csr_re, csr_we;
  logic [XLEN-1:0] csr_rdata, csr_wdata;
  logic            core_csr_we = 1'b0;
  logic [11:0]     core_csr_addr = '0;
  logic [XLEN-1:0] core_csr_wdata = '0;
  logic            redir_valid;
  logic [XLEN-1:0] redir_pc;
  logic            redir_ready = 1'b0;

  always #5 clk = ~clk;

  ysyx_23060240_trap_ctrl #(.XLEN(XLEN), .VECTOR_EN(1'b1)) dut (
    .clk(clk), .rst_n(rst_n),
    .exc_valid_i(exc_valid), .exc_cause_i(exc_cause), .exc_pc_i(exc_pc),
    .mret_valid_i(mret_valid), .irq_i(irq),
    .req_ready_o(req_ready), .busy_o(busy),
    .csr_addr_o(csr_addr), .csr_re_o(csr_re), .csr_rdata_i(csr_rdata),
    .csr_we_o(csr_we), .csr_wdata_o(csr_wdata),
    .core_csr_we_i(core_csr_we), .core_csr_addr_i(core_csr_addr),
    .core_csr_wdata_i(core_csr_wdata),
    .redir_valid_o(redir_valid), .redir_pc_o(redir_pc), .redir_ready_i(redir_ready)
  );

  // Bench-side CSR file: DUT writes, or setup writes from the stimulus.
  logic [31:0] r_mstatus = '0, r_mtvec = '0, r_mepc = '0, r_mcause = '0;
  logic        tb_wr = 1'b0;
  logic [11:0] tb_waddr = '0;
  logic [31:0] tb_wdata = '0;
  logic [11:0] wa;
  logic [31:0] wd;

  assign wa = csr_we ? csr_addr : tb_waddr;
  assign wd = csr_we ? csr_wdata : tb_wdata;

  always @(posedge clk) begin
    if (csr_we || tb_wr) begin
      case (wa)
        12'h300: r_mstatus <= wd;
        12'h305: r_mtvec   <= wd;
        12'h341: r_mepc    <= wd;
        12'h342: r_mcause  <= wd;
        default: ;
      endcase
    end
  end

  always_comb begin
    case (csr_addr)
      12'h300: csr_rdata = r_mstatus;
      12'h305: csr_rdata = r_mtvec;
      12'h341: csr_rdata = r_mepc;
      12'h342: csr_rdata = r_mcause;
      default: csr_rdata = '0;
    endcase
  end

  int n_chk = 0;
  int n_pass = 0;
  bit m_mie = 1'b0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  task automatic clear_req();
    exc_valid = 1'b0; mret_valid = 1'b0; irq = 1'b0;
    exc_cause = '0; exc_pc = '0;
    core_csr_we = 1'b0; core_csr_addr = '0; core_csr_wdata = '0;
  endtask

  // One idle-cycle CSR setup write; a snoop write is also seen by the DUT.
  task automatic csr_setup(input logic [11:0] addr, input logic [31:0] data, input bit snoop);
    @(negedge clk);
    tb_wr = 1'b1; tb_waddr = addr; tb_wdata = data;
    if (snoop) begin
      core_csr_we = 1'b1; core_csr_addr = addr; core_csr_wdata = data;
    end
    @(negedge clk);
    tb_wr = 1'b0;
    core_csr_we = 1'b0;
    if (snoop && addr == 12'h300) m_mie = data[3];
  endtask

  task automatic transact(input bit ev, input logic [3:0] cause, input logic [31:0] pc,
                          input bit irq_in, input bit mret_in, input int wait_n);
    int kind, e_lat, cnt;
    logic [31:0] e_status, e_epc, e_cause, e_pc;
    bit e_mie;
    kind = ev ? 1 : (irq_in && m_mie) ? 2 : mret_in ? 3 : 0;
    e_status = r_mstatus; e_epc = r_mepc; e_cause = r_mcause; e_pc = '0;
    e_lat = 0; e_mie = m_mie;
    if (kind == 1 || kind == 2) begin
      e_status[7] = r_mstatus[3];
      e_status[3] = 1'b0;
      e_status[12:11] = 2'b11;
      e_epc = pc;
      e_cause = (kind == 1) ? {28'd0, cause} : 32'h8000_0007;
      e_pc = r_mtvec & ~32'h3;
      if (kind == 2 && r_mtvec[1:0] == 2'b01) e_pc = e_pc + 32'd28;
      e_lat = 6;
      e_mie = 1'b0;
    end else if (kind == 3) begin
      e_status[3] = r_mstatus[7];
      e_status[7] = 1'b1;
      e_status[12:11] = 2'b11;
      e_pc = r_mepc & ~32'h3;
      e_lat = 4;
      e_mie = r_mstatus[7];
    end
    @(negedge clk);
    chk("req_ready_idle", 32'(req_ready), 1);
    exc_valid = ev; exc_cause = cause; exc_pc = pc; irq = irq_in; mret_valid = mret_in;
    redir_ready = (wait_n == 0);
    @(negedge clk);
    if (kind == 0) begin
      chk("ignored_busy", 32'(busy), 0);
      chk("ignored_strobe", 32'(csr_re) | 32'(csr_we), 0);
      clear_req();
      redir_ready = 1'b0;
      return;
    end
    cnt = 1;
    while (!redir_valid && cnt < 12) begin
      chk("seq_busy", 32'(busy), 1);
      chk("one_strobe", 32'(csr_re) + 32'(csr_we), 1);
      exc_valid = 1'($urandom); irq = 1'($urandom); mret_valid = 1'($urandom);
      exc_pc = $urandom; exc_cause = 4'($urandom);
      core_csr_we = 1'($urandom); core_csr_addr = 12'h300; core_csr_wdata = $urandom;
      @(negedge clk);
      cnt++;
    end
    clear_req();
    chk("latency", 32'(cnt), 32'(e_lat));
    chk("redir_pc", redir_pc, e_pc);
    chk("redir_strobe", 32'(csr_re) | 32'(csr_we), 0);
    for (int i = 0; i < wait_n; i++) begin
      @(negedge clk);
      chk("hold_valid", 32'(redir_valid), 1);
      chk("hold_pc", redir_pc, e_pc);
      chk("hold_busy", 32'(busy), 1);
    end
    redir_ready = 1'b1;
    @(negedge clk);
    redir_ready = 1'b0;
    chk("done_idle", 32'(req_ready), 1);
    chk("done_valid", 32'(redir_valid), 0);
    chk("mstatus", r_mstatus, e_status);
    chk("mepc", r_mepc, e_epc);
    chk("mcause", r_mcause, e_cause);
    m_mie = e_mie;
  endtask

  initial begin
    logic [31:0] old_cause;
    logic [3:0] causes [3];
    causes[0] = 4'd0; causes[1] = 4'd2; causes[2] = 4'd11;

    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_ready", 32'(req_ready), 1);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_strobes", 32'(csr_re) | 32'(csr_we) | 32'(redir_valid), 0);
    chk("rst_addr", 32'(csr_addr), 0);
    chk("rst_wdata", csr_wdata, 0);
    chk("rst_redir_pc", redir_pc, 0);
    rst_n = 1'b1;
    m_mie = 1'b0;

    // mie_q is clear after reset, so a lone interrupt is not taken.
    transact(1'b0, 4'd0, 32'h8000_0000, 1'b1, 1'b0, 0);

    csr_setup(12'h300, 32'h0000_1808, 1'b1);
    csr_setup(12'h305, 32'h8000_0100, 1'b0);
    transact(1'b1, 4'd11, 32'h8000_0010, 1'b0, 1'b0, 0);
    chk("ecall_mstatus", r_mstatus, 32'h0000_1880);
    chk("ecall_mcause", r_mcause, 32'h0000_000b);

    csr_setup(12'h341, 32'h8000_0014, 1'b0);
    transact(1'b0, 4'd0, 32'h0, 1'b0, 1'b1, 0);
    chk("mret_mstatus", r_mstatus, 32'h0000_1888);

    // mret restored MIE, so this interrupt must be taken.
    csr_setup(12'h305, 32'h8000_0101, 1'b0);
    transact(1'b0, 4'd0, 32'h8000_0020, 1'b1, 1'b0, 1);
    chk("irq_mcause", r_mcause, 32'h8000_0007);
    chk("irq_mepc", r_mepc, 32'h8000_0020);

    csr_setup(12'h300, 32'h0000_1808, 1'b1);
    transact(1'b1, 4'd2, 32'h8000_0030, 1'b1, 1'b1, 0);
    chk("prio_mcause", r_mcause, 32'h0000_0002);
    transact(1'b0, 4'd0, 32'h8000_0034, 1'b1, 1'b0, 0);

    transact(1'b1, 4'd0, 32'h8000_0044, 1'b0, 1'b0, 5);

    // Asynchronous reset while the mcause write is pending.
    old_cause = r_mcause;
    @(negedge clk);
    exc_valid = 1'b1; exc_cause = 4'd2; exc_pc = 32'h8000_0040;
    @(negedge clk);
    clear_req();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    chk("arst_busy", 32'(busy), 0);
    chk("arst_strobes", 32'(csr_re) | 32'(csr_we) | 32'(redir_valid), 0);
    chk("arst_addr", 32'(csr_addr), 0);
    chk("arst_wdata", csr_wdata, 0);
    chk("arst_mepc", r_mepc, 32'h8000_0040);
    chk("arst_mcause", r_mcause, old_cause);
    @(negedge clk);
    rst_n = 1'b1;
    m_mie = 1'b0;
    @(negedge clk);
    chk("arst_ready", 32'(req_ready), 1);

    for (int it = 0; it < 40; it++) begin
      if ($urandom_range(0, 2) == 0)
        csr_setup(12'h300, $urandom & 32'hffff_e777, 1'b1);
      csr_setup(12'h305, $urandom, 1'b0);
      csr_setup(12'h341, $urandom, 1'b0);
      transact(1'($urandom_range(0, 3) == 0), causes[$urandom_range(0, 2)], $urandom,
               1'($urandom), 1'($urandom), int'($urandom_range(0, 3)));
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
